// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR decoder: FSM state encoding and the
// tick windows used to classify mark/space durations.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_TRAIL
    } ir_state_e;

    localparam logic [7:0] LEAD_MARK_MIN    = 8'd140;
    localparam logic [7:0] LEAD_MARK_MAX    = 8'd180;
    localparam logic [7:0] LEAD_SPACE_MIN   = 8'd70;
    localparam logic [7:0] LEAD_SPACE_MAX   = 8'd90;
    localparam logic [7:0] REPEAT_SPACE_MIN = 8'd30;
    localparam logic [7:0] REPEAT_SPACE_MAX = 8'd50;
    localparam logic [7:0] BIT_MARK_MIN     = 8'd6;
    localparam logic [7:0] BIT_MARK_MAX     = 8'd14;
    localparam logic [7:0] ZERO_SPACE_MIN   = 8'd6;
    localparam logic [7:0] ZERO_SPACE_MAX   = 8'd14;
    localparam logic [7:0] ONE_SPACE_MIN    = 8'd24;
    localparam logic [7:0] ONE_SPACE_MAX    = 8'd36;
    localparam logic [7:0] DUR_SAT          = 8'd255;

    function automatic logic in_window(input logic [7:0] d,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/nec_pulse_timer.sv
// Synchronises the IR pin, detects edges and measures the interval since the
// previous edge in ticks (saturating at 255).
module nec_pulse_timer
    import ir_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 4177
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ir_i,
    output logic       rise_o,
    output logic       fall_o,
    output logic [7:0] duration_o,
    output logic       sat_o
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    logic          sync1_q, sync2_q, sync3_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic          rise_q, fall_q;
    logic [7:0]    dur_q;
    logic          edge_rise, edge_fall, tick;

    assign edge_fall = sync3_q & ~sync2_q;
    assign edge_rise = ~sync3_q & sync2_q;
    assign tick      = (pre_q == TICK_LAST);

    // The reported duration includes this cycle's increment, so an edge that
    // coincides with saturation is reported as 255.
    always_comb begin
        cnt_inc = (tick && (cnt_q != DUR_SAT)) ? cnt_q + 8'd1 : cnt_q;
        pre_d   = tick ? '0 : pre_q + PW'(1);
        cnt_d   = cnt_inc;
        if (edge_fall || edge_rise) begin
            pre_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            pre_q   <= '0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            dur_q   <= '0;
        end else begin
            sync1_q <= ir_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            rise_q  <= edge_rise;
            fall_q  <= edge_fall;
            if (edge_fall || edge_rise) begin
                dur_q <= cnt_inc;
            end
        end
    end

    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign duration_o = dur_q;
    assign sat_o      = (cnt_q == DUR_SAT);

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: classifies mark/space durations from the pulse
// timer and assembles 32-bit frames, repeat codes and error indications.
module nec_ir_decoder
    import ir_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 4177
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ir_rx_in,
    output logic [31:0] code_out,
    output logic        valid_out,
    output logic        repeat_out,
    output logic        error_out,
    output logic        busy_out
);

    logic       rise, fall, sat;
    logic [7:0] duration;

    nec_pulse_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_timer (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .ir_i      (ir_rx_in),
        .rise_o    (rise),
        .fall_o    (fall),
        .duration_o(duration),
        .sat_o     (sat)
    );

    ir_state_e   state_q;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q;
    logic [31:0] code_q;
    logic        valid_q, repeat_q, error_q;

    logic lead_mark_ok, lead_space_ok, repeat_space_ok, bit_mark_ok;
    logic zero_ok, one_ok, frame_ok;

    always_comb begin
        lead_mark_ok    = in_window(duration, LEAD_MARK_MIN, LEAD_MARK_MAX);
        lead_space_ok   = in_window(duration, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
        repeat_space_ok = in_window(duration, REPEAT_SPACE_MIN, REPEAT_SPACE_MAX);
        bit_mark_ok     = in_window(duration, BIT_MARK_MIN, BIT_MARK_MAX);
        zero_ok         = in_window(duration, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
        one_ok          = in_window(duration, ONE_SPACE_MIN, ONE_SPACE_MAX);
        shift_d         = {shift_q[30:0], one_ok};
        frame_ok        = (shift_d[15:8] == ~shift_d[7:0]);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall) state_q <= ST_LEAD_MARK;
                end
                ST_LEAD_MARK: begin
                    if (rise && lead_mark_ok) begin
                        state_q <= ST_LEAD_SPACE;
                    end else if (rise || sat) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (fall && lead_space_ok) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_BIT_MARK;
                    end else if (fall && repeat_space_ok) begin
                        repeat_q <= 1'b1;
                        state_q  <= ST_TRAIL;
                    end else if (fall || sat) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BIT_MARK: begin
                    if (rise && bit_mark_ok) begin
                        state_q <= ST_BIT_SPACE;
                    end else if (rise || sat) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BIT_SPACE: begin
                    if (fall && (zero_ok || one_ok)) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == 5'd31) begin
                            if (frame_ok) begin
                                code_q  <= shift_d;
                                valid_q <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                            state_q <= ST_TRAIL;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            state_q   <= ST_BIT_MARK;
                        end
                    end else if (fall || sat) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_TRAIL: begin
                    if (rise || sat) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign code_out   = code_q;
    assign valid_out  = valid_q;
    assign repeat_out = repeat_q;
    assign error_out  = error_q;
    assign busy_out   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder with TICK_CYCLES = 4.
module tb_nec_ir_decoder;

    localparam int unsigned TICK = 4;
    localparam int unsigned GAP  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir  = 1'b1;
    logic [31:0] code;
    logic        valid, rpt, err, busy;

    nec_ir_decoder #(.TICK_CYCLES(TICK)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .ir_rx_in  (ir),
        .code_out  (code),
        .valid_out (valid),
        .repeat_out(rpt),
        .error_out (err),
        .busy_out  (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_valid = 0, n_rpt = 0, n_err = 0, n_overlap = 0;
    int unsigned last_lat = 0, last_edge_cyc = 0;
    int unsigned errors = 0, checks = 0;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (rpt)   n_rpt++;
        if (err)   n_err++;
        if ((int'(valid) + int'(rpt) + int'(err)) > 1) n_overlap++;
        if (valid || rpt || err) last_lat = cyc - last_edge_cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic seg(input logic lvl, input int unsigned ticks);
        if (lvl != ir) last_edge_cyc = cyc;
        ir = lvl;
        repeat (ticks * TICK) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] c, input int unsigned n, input int unsigned one_sp);
        for (int i = 0; i < int'(n); i++) begin
            seg(1'b0, 10);
            seg(1'b1, c[31-i] ? one_sp : 10);
        end
    endtask

    task automatic send_frame(input logic [31:0] c, input int unsigned lead, input int unsigned one_sp);
        seg(1'b0, lead);
        seg(1'b1, 80);
        send_bits(c, 32, one_sp);
        seg(1'b0, 10);
        seg(1'b1, GAP);
    endtask

    typedef enum int {K_FRAME, K_REPEAT, K_MARK} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] frame;
        int unsigned lead_mark;
        int unsigned one_space;
        int unsigned exp_v;
        int unsigned exp_r;
        int unsigned exp_e;
        logic [31:0] exp_code;
    } vec_t;

    vec_t        vecs[9];
    vec_t        v;
    int unsigned s_v, s_r, s_e, c0;

    initial begin
        vecs[0] = '{K_FRAME,  32'h20DF5BA4, 160, 30, 1, 0, 0, 32'h20DF5BA4};
        vecs[1] = '{K_REPEAT, 32'h0,        160, 30, 0, 1, 0, 32'h20DF5BA4};
        vecs[2] = '{K_FRAME,  32'h20DF5BA5, 160, 30, 0, 0, 1, 32'h20DF5BA4};
        vecs[3] = '{K_MARK,   32'h0,         89, 30, 0, 0, 1, 32'h20DF5BA4};
        vecs[4] = '{K_FRAME,  32'h20DF5AA5, 160, 30, 1, 0, 0, 32'h20DF5AA5};
        vecs[5] = '{K_FRAME,  32'h12ED34CB, 140, 24, 1, 0, 0, 32'h12ED34CB};
        vecs[6] = '{K_FRAME,  32'hA55A00FF, 180, 36, 1, 0, 0, 32'hA55A00FF};
        vecs[7] = '{K_MARK,   32'h0,        181, 30, 0, 0, 1, 32'hA55A00FF};
        vecs[8] = '{K_MARK,   32'h0,        139, 30, 0, 0, 1, 32'hA55A00FF};

        rst = 1'b1;
        ir  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code",  code,  32'h0);
        check("rst_busy",  busy,  1'b0);
        check("rst_pulse", {valid, rpt, err}, 3'b000);
        rst = 1'b0;
        seg(1'b1, 10);

        for (int i = 0; i < 9; i++) begin
            v   = vecs[i];
            s_v = n_valid;
            s_r = n_rpt;
            s_e = n_err;
            case (v.kind)
                K_FRAME: send_frame(v.frame, v.lead_mark, v.one_space);
                K_REPEAT: begin
                    seg(1'b0, v.lead_mark);
                    seg(1'b1, 40);
                    seg(1'b0, 10);
                    seg(1'b1, GAP);
                end
                default: begin
                    seg(1'b0, v.lead_mark);
                    seg(1'b1, GAP);
                end
            endcase
            check($sformatf("v%0d_valid_cnt", i),  n_valid - s_v, v.exp_v);
            check($sformatf("v%0d_repeat_cnt", i), n_rpt - s_r,   v.exp_r);
            check($sformatf("v%0d_error_cnt", i),  n_err - s_e,   v.exp_e);
            check($sformatf("v%0d_code", i),       code,          v.exp_code);
            check($sformatf("v%0d_busy", i),       busy,          1'b0);
            check($sformatf("v%0d_latency", i),    last_lat,      4);
        end

        // Asynchronous reset while in bit 16's space; line stays high.
        seg(1'b0, 160);
        seg(1'b1, 80);
        send_bits(32'h20DF5BA4, 16, 30);
        seg(1'b0, 10);
        ir = 1'b1;
        repeat (5 * TICK) @(posedge clk);
        #2;
        check("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_code",  code, 32'h0);
        check("midrst_busy",  busy, 1'b0);
        check("midrst_pulse", {valid, rpt, err}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s_v = n_valid;
        s_r = n_rpt;
        s_e = n_err;
        seg(1'b1, 300);
        check("postrst_quiet", (n_valid - s_v) + (n_rpt - s_r) + (n_err - s_e), 0);
        send_frame(32'h20DF5BA4, 160, 30);
        check("postrst_valid_cnt", n_valid - s_v, 1);
        check("postrst_error_cnt", n_err - s_e,   0);
        check("postrst_code",      code,          32'h20DF5BA4);

        // Line held high after bit 20's mark until the counter saturates.
        seg(1'b0, 160);
        seg(1'b1, 80);
        send_bits(32'h20DF5BA4, 20, 30);
        seg(1'b0, 10);
        s_e = n_err;
        c0  = cyc;
        ir  = 1'b1;
        repeat (1023) @(posedge clk);
        @(negedge clk);
        check("sat_err_before",  err,  1'b0);
        check("sat_busy_before", busy, 1'b1);
        @(negedge clk);
        check("sat_err_at",      err,  1'b1);
        check("sat_cycle",       cyc - c0, 1024);
        @(negedge clk);
        check("sat_err_after",   err,  1'b0);
        check("sat_busy_after",  busy, 1'b0);
        repeat (80 * TICK) @(posedge clk);
        #1;
        check("sat_error_cnt",   n_err - s_e, 1);
        check("sat_code",        code, 32'h20DF5BA4);

        check("pulse_overlap", n_overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
